elevator_car_ctrl: RTL and testbench
====================================

// Module: elevator_car_ctrl
//
// PURPOSE
//   Consumer end of the floor-request queue: pops one target floor at a time over a
//   valid/ready handshake and moves the car one floor per MOVE_CYCLES toward it.
//   On arrival it opens the door for DOOR_CYCLES, then accepts the next request.
//   Sits between the request queue (producer) and the car status/display logic.
//
// PARAMETERS
//   NUM_FLOORS   8   floors served, numbered 0..NUM_FLOORS-1
//   FLOOR_W      3   floor index width; must be >= $clog2(NUM_FLOORS)
//   MOVE_CYCLES  4   clock cycles to travel one floor (>=1)
//   DOOR_CYCLES  6   clock cycles door stays open (>=1)
//
// PORTS
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   req_valid    in   1        queue presents a request
//   req_floor    in   FLOOR_W  requested target floor
//   req_ready    out  1        ctrl accepts a request this cycle (high only in IDLE)
//   cur_floor    out  FLOOR_W  current car floor, registered
//   moving_up    out  1        car travelling upward
//   moving_down  out  1        car travelling downward
//   door_open    out  1        door open
//   arrived      out  1        1-cycle pulse on reaching the target floor
//   req_err      out  1        1-cycle pulse: accepted request had req_floor >= NUM_FLOORS
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, cur_floor=0, moving_*=0, door_open=0,
//     arrived=0, req_err=0, timer=0. req_ready is decoded from state, so it reads 1.
//   - Handshake: transfer at a rising edge when req_valid & req_ready. Producer holds
//     req_floor stable while req_valid=1 and unaccepted. Exactly one pop per transfer.
//   - FSM IDLE -> MOVE | DOOR | IDLE; MOVE -> MOVE | DOOR; DOOR -> DOOR | IDLE.
//   - IDLE, transfer at edge k:
//       req_floor >= NUM_FLOORS: request dropped; req_err=1 for cycle k..k+1; stay IDLE.
//       req_floor == cur_floor:  -> DOOR; door_open=1, arrived=1 from edge k.
//       otherwise:               latch target; -> MOVE; moving_up/down set from edge k.
//   - MOVE: timer counts MOVE_CYCLES; at each expiry cur_floor +/-1 (edges k+M, k+2M...).
//     The edge where cur_floor becomes target: -> DOOR, moving_*=0, door_open=1,
//     arrived=1 (one cycle). No wrap-around: cur_floor never leaves 0..NUM_FLOORS-1.
//   - DOOR: door_open held exactly DOOR_CYCLES cycles; then -> IDLE, door_open=0,
//     req_ready=1 in the same cycle (new request may transfer at that next edge).
//   - req_valid ignored outside IDLE; no request is lost or accepted twice.
//   - moving_up & moving_down never both 1; door_open never 1 while moving.
//   - Reset asserted mid-MOVE/DOOR: immediate return to reset values; the in-flight
//     target is discarded (producer must re-issue).
//
// STRUCTURE
//   - Package elevator_pkg: state encodings (ST_IDLE, ST_MOVE, ST_DOOR), default
//     NUM_FLOORS/FLOOR_W/MOVE_CYCLES/DOOR_CYCLES, timer width function.
//   - One sub-module: elev_timer — loadable down-counter with 1-cycle expire pulse,
//     shared by MOVE and DOOR phases. FSM, target register and floor counter stay here.
//
// TESTING (defaults unless stated; edge 0 = transfer edge)
//   1. Hold rst_n=0 -> cur_floor=0, moving_*=0, door_open=0, arrived=0, req_ready=1.
//   2. At floor 0 request 3 -> moving_up=1; cur_floor 1@4, 2@8, 3@12 with arrived pulse
//      @12; door_open edges 12..18; req_ready=1 after edge 18.
//   3. At floor 3 request 3 -> no motion; arrived + door_open from edge 0; door closes @6.
//   4. At floor 3 request 0 -> moving_down=1; cur_floor 0 @12; arrived once.
//   5. NUM_FLOORS=6, request 7 -> req_err pulse one cycle, state IDLE, cur_floor unchanged.
//   6. req_valid held with floor 5 through a trip to 3 -> accepted only once,
//      at the first edge after the door closes; rst_n pulse @6 mid-MOVE -> all outputs
//      clear immediately, cur_floor=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Package: elevator_pkg
//
// Shared definitions for the elevator car controller:
//   state_t       - FSM state encoding (ST_IDLE, ST_MOVE, ST_DOOR)
//   DEF_*         - default parameter values for the controller
//   timer_w()     - width of the shared down-counter, sized for the longer phase
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam int DEF_NUM_FLOORS  = 8;
  localparam int DEF_FLOOR_W     = 3;
  localparam int DEF_MOVE_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES = 6;

  // The counter is loaded with (cycles - 1), so it must hold values up to
  // max(move, door) - 1. A width of at least 1 keeps the vector legal.
  function automatic int timer_w(input int move_cycles, input int door_cycles);
    int longest;
    int w;
    longest = (move_cycles > door_cycles) ? move_cycles : door_cycles;
    w = $clog2(longest);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/elevator_car_ctrl_timer.sv
// Module: elev_timer
//
// Loadable down-counter shared by the MOVE and DOOR phases.
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   load      in   1   load load_val into the counter this edge
//   en        in   1   counter is in use (counts down, may expire)
//   load_val  in   W   value to load (phase length minus one)
//   expire    out  1   high for the single cycle the counter sits at zero while
//                      enabled; the owner reloads or leaves the phase on that edge
module elev_timer
  import elevator_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Deliberately independent of load: the owner derives load from expire.
  assign expire = en && (count == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Module: elevator_car_ctrl
//
// Consumer end of the floor-request queue. Pops one target floor at a time
// over a valid/ready handshake, moves the car one floor every MOVE_CYCLES
// toward it, then holds the door open for DOOR_CYCLES before taking the next
// request.
// Ports:
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   req_valid    in   1        queue presents a request
//   req_floor    in   FLOOR_W  requested target floor
//   req_ready    out  1        request accepted this cycle (high only in IDLE)
//   cur_floor    out  FLOOR_W  current car floor, registered
//   moving_up    out  1        car travelling upward
//   moving_down  out  1        car travelling downward
//   door_open    out  1        door open
//   arrived      out  1        1-cycle pulse on reaching the target floor
//   req_err      out  1        1-cycle pulse: accepted floor was out of range
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_ready,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               arrived,
  output logic               req_err
);

  localparam int TW = timer_w(MOVE_CYCLES, DOOR_CYCLES);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

  state_t             state, state_nxt;
  logic [FLOOR_W-1:0] target, target_nxt;
  logic [FLOOR_W-1:0] cur_floor_nxt;
  logic [FLOOR_W-1:0] step_floor;
  logic               moving_up_nxt, moving_down_nxt;
  logic               door_open_nxt, arrived_nxt, req_err_nxt;
  logic               tmr_load, tmr_en, tmr_expire;
  logic [TW-1:0]      tmr_val;

  elev_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign req_ready = (state == ST_IDLE);

  // Target is always in range and the direction always points at it, so the
  // floor counter stops on the target and can never step past either end.
  assign step_floor = moving_up ? (cur_floor + FLOOR_W'(1))
                                : (cur_floor - FLOOR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      target      <= '0;
      cur_floor   <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
      arrived     <= 1'b0;
      req_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      target      <= target_nxt;
      cur_floor   <= cur_floor_nxt;
      moving_up   <= moving_up_nxt;
      moving_down <= moving_down_nxt;
      door_open   <= door_open_nxt;
      arrived     <= arrived_nxt;
      req_err     <= req_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    target_nxt      = target;
    cur_floor_nxt   = cur_floor;
    moving_up_nxt   = moving_up;
    moving_down_nxt = moving_down;
    door_open_nxt   = door_open;
    arrived_nxt     = 1'b0;
    req_err_nxt     = 1'b0;
    tmr_load        = 1'b0;
    tmr_en          = 1'b0;
    tmr_val         = '0;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (32'(req_floor) >= NUM_FLOORS) begin
            // Out-of-range request is consumed and dropped.
            req_err_nxt = 1'b1;
          end else if (req_floor == cur_floor) begin
            state_nxt     = ST_DOOR;
            door_open_nxt = 1'b1;
            arrived_nxt   = 1'b1;
            tmr_load      = 1'b1;
            tmr_val       = DOOR_LOAD;
          end else begin
            state_nxt       = ST_MOVE;
            target_nxt      = req_floor;
            moving_up_nxt   = (req_floor > cur_floor);
            moving_down_nxt = (req_floor < cur_floor);
            tmr_load        = 1'b1;
            tmr_val         = MOVE_LOAD;
          end
        end
      end

      ST_MOVE: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          cur_floor_nxt = step_floor;
          tmr_load      = 1'b1;
          if (step_floor == target) begin
            state_nxt       = ST_DOOR;
            moving_up_nxt   = 1'b0;
            moving_down_nxt = 1'b0;
            door_open_nxt   = 1'b1;
            arrived_nxt     = 1'b1;
            tmr_val         = DOOR_LOAD;
          end else begin
            tmr_val         = MOVE_LOAD;
          end
        end
      end

      ST_DOOR: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          state_nxt     = ST_IDLE;
          door_open_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt       = ST_IDLE;
        moving_up_nxt   = 1'b0;
        moving_down_nxt = 1'b0;
        door_open_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Testbench: tb_elevator_car_ctrl
//
// Drives directed and randomized floor requests into elevator_car_ctrl and
// compares every cycle of every trip against a timeline computed from the
// trip geometry (distance * MOVE_CYCLES travel, then DOOR_CYCLES door time).
module tb_elevator_car_ctrl;

  localparam int NF = 6;
  localparam int FW = 3;
  localparam int MC = 4;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          req_ready;
  logic [FW-1:0] cur_floor;
  logic          moving_up, moving_down, door_open, arrived, req_err;

  logic [8:0]    obs;

  int checks   = 0;
  int failures = 0;
  int m_floor  = 0;

  always #5 clk = ~clk;

  assign obs = {cur_floor, moving_up, moving_down, door_open, arrived, req_err, req_ready};

  elevator_car_ctrl #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .MOVE_CYCLES(MC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_floor  (req_floor),
    .req_ready  (req_ready),
    .cur_floor  (cur_floor),
    .moving_up  (moving_up),
    .moving_down(moving_down),
    .door_open  (door_open),
    .arrived    (arrived),
    .req_err    (req_err)
  );

  // Issue one request from the idle car (called at a falling edge) and check
  // every cycle until the car is idle again. With hold=1 the request line stays
  // asserted with next_f so the following request transfers at the first edge
  // after the door closes.
  task automatic do_request(input int f, input bit hold, input int next_f);
    int c, d, t_trav, total, fl;
    logic [8:0] exp;
    c = m_floor;
    req_floor = FW'(f);
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_req floor=%0d got=%b exp=1", f, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) req_floor = FW'(next_f);
    else req_valid = 1'b0;

    if (f >= NF) begin
      exp = {FW'(c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL bad_req_pulse floor=%0d got=%b exp=%b", f, obs, exp);
      end
      @(negedge clk);
      exp = {FW'(c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL bad_req_after floor=%0d got=%b exp=%b", f, obs, exp);
      end
      return;
    end

    d      = (f > c) ? (f - c) : (c - f);
    t_trav = d * MC;
    total  = t_trav + DC;
    for (int j = 0; j <= total; j++) begin
      if (j >= t_trav) fl = f;
      else fl = (f > c) ? (c + j / MC) : (c - j / MC);
      exp = {FW'(fl), (j < t_trav) && (f > c), (j < t_trav) && (f < c),
             (j >= t_trav) && (j < total), (j == t_trav), 1'b0, (j == total)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL trip_%0d_to_%0d cyc=%0d got=%b exp=%b", c, f, j, obs, exp);
      end
      if (j < total) @(negedge clk);
    end
    m_floor = f;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_floor = '0;
    repeat (3) @(negedge clk);
    exp = {FW'(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs, exp);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=%b", obs, exp);
    end
    m_floor = 0;
  endtask

  task automatic test_trip_up();
    do_request(3, 1'b0, 0);
  endtask

  task automatic test_bad_floor();
    do_request(7, 1'b0, 0);
    do_request(6, 1'b0, 0);
  endtask

  task automatic test_same_floor();
    do_request(3, 1'b0, 0);
  endtask

  task automatic test_trip_down();
    do_request(0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    do_request(3, 1'b1, 5);
    do_request(5, 1'b0, 0);
    exp = {FW'(5), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL no_double_accept cyc=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_move();
    logic [8:0] exp;
    req_floor = FW'(0);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    exp = {FW'(4), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL mid_move_before_rst got=%b exp=%b", obs, exp);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp = {FW'(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL async_rst_clear got=%b exp=%b", obs, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_floor = 0;
    repeat (MC * 2) @(negedge clk);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL target_discarded got=%b exp=%b", obs, exp);
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    int gap;
    for (int n = 0; n < 25; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        exp = {FW'(m_floor), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL rand_idle n=%0d got=%b exp=%b", n, obs, exp);
        end
      end
      do_request(int'($urandom_range(0, 7)), 1'b0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_trip_up();
    test_bad_floor();
    test_same_floor();
    test_trip_down();
    test_back_to_back();
    test_reset_mid_move();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
